// File: rtl/tl45_divider.sv
// tl45_divider: fixed-latency radix-2 restoring divider, signed or unsigned, with divide-by-zero flag
module tl45_divider #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_wr,
  input  logic         i_signed,
  input  logic [W-1:0] i_numerator,
  input  logic [W-1:0] i_denominator,
  output logic         o_busy,
  output logic         o_valid,
  output logic         o_err,
  output logic [W-1:0] o_quotient,
  output logic [W-1:0] o_remainder
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
  state_t r_state, w_next;
  // r_pend marks the single alignment cycle right after capture: it keeps the
  // nonzero-divisor latency at W+2 busy cycles and delays divide-by-zero to DONE
  // one cycle later, without ever raising o_busy for the zero case.
  logic r_pend, r_qneg, r_rneg;
  logic [CW-1:0] r_cnt;
  logic [W-1:0] r_q, r_r, r_d;
  logic w_accept, w_zero, w_nneg, w_dneg;
  logic [W-1:0] w_nmag, w_dmag;
  logic [W:0] w_sh, w_diff;
  assign w_accept = (r_state == IDLE) && !r_pend && i_wr;
  assign w_zero   = (i_denominator == '0);
  assign w_nneg   = i_signed & i_numerator[W-1];
  assign w_dneg   = i_signed & i_denominator[W-1];
  assign w_nmag   = w_nneg ? -i_numerator : i_numerator;
  assign w_dmag   = w_dneg ? -i_denominator : i_denominator;
  assign w_sh     = {r_r, r_q[W-1]};
  assign w_diff   = w_sh - {1'b0, r_d};
  assign o_busy   = (r_state == CALC) || (r_state == FIXUP);
  assign o_valid  = (r_state == DONE);
  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Next-state: zero divisor skips straight to DONE after the alignment cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = r_pend ? DONE : (w_accept && !w_zero) ? CALC : IDLE;
      CALC:    w_next = (!r_pend && r_cnt == '0) ? FIXUP : CALC;
      FIXUP:   w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  // Operand capture, shift-subtract iterations and result write-back
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pend      <= 1'b0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_cnt       <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_d         <= '0;
      o_err       <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
    end else begin
      r_pend <= w_accept;
      if (w_accept) begin
        r_q         <= w_zero ? i_numerator : w_nmag;
        r_d         <= w_dmag;
        r_r         <= '0;
        r_cnt       <= CNT_MAX;
        r_qneg      <= w_nneg ^ w_dneg;
        r_rneg      <= w_nneg;
        o_err       <= 1'b0;
        o_quotient  <= '0;
        o_remainder <= '0;
      end
      if (r_state == IDLE && r_pend) begin
        o_err       <= 1'b1;
        o_quotient  <= '1;
        o_remainder <= r_q;
      end
      if (r_state == CALC && !r_pend) begin
        r_r   <= w_diff[W] ? w_sh[W-1:0] : w_diff[W-1:0];
        r_q   <= {r_q[W-2:0], ~w_diff[W]};
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == FIXUP) begin
        o_quotient  <= r_qneg ? -r_q : r_q;
        o_remainder <= r_rneg ? -r_r : r_r;
      end
    end
  end
endmodule

// File: tb/tb_tl45_divider.sv
// tb_tl45_divider: randomized and directed checks of tl45_divider against an arithmetic reference
module tb_tl45_divider;
  logic i_clk = 0, i_reset_n = 0, i_wr = 0, i_signed = 0;
  logic [31:0] i_numerator = 0, i_denominator = 0;
  logic o_busy, o_valid, o_err;
  logic [31:0] o_quotient, o_remainder;
  int pass = 0, total = 0;

  tl45_divider #(.W(32)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_wr(i_wr), .i_signed(i_signed),
    .i_numerator(i_numerator), .i_denominator(i_denominator),
    .o_busy(o_busy), .o_valid(o_valid), .o_err(o_err),
    .o_quotient(o_quotient), .o_remainder(o_remainder)
  );

  always #5 i_clk = ~i_clk;

  function automatic void model(input logic [31:0] n, d, input logic s,
                                output logic [31:0] q, r, output logic e);
    longint a, b;
    a = s ? longint'($signed(n)) : longint'(n);
    b = s ? longint'($signed(d)) : longint'(d);
    if (d == 0) begin q = '1; r = n; e = 1; end
    else begin q = 32'(a / b); r = 32'(a % b); e = 0; end
  endfunction

  task automatic do_op(input logic [31:0] n, d, input logic s,
                       output logic [31:0] q, r, output logic e, output int lat, output int busy,
                       output logic [64:0] cleared);
    @(negedge i_clk);
    i_wr = 1; i_numerator = n; i_denominator = d; i_signed = s;
    @(posedge i_clk);
    lat = 0; busy = 0; cleared = '1;
    while (lat < 100) begin
      @(negedge i_clk);
      lat++;
      if (lat == 1) cleared = {o_err, o_quotient, o_remainder};
      if (o_valid) break;
      busy += int'(o_busy);
      i_wr = 1'($urandom); i_numerator = $urandom; i_denominator = $urandom; i_signed = 1'($urandom);
    end
    q = o_quotient; r = o_remainder; e = o_err;
    i_wr = 0;
  endtask

  task automatic test_reset;
    i_reset_n = 0;
    repeat (3) @(negedge i_clk);
    total++;
    if ({o_busy, o_valid, o_err, o_quotient, o_remainder} !== 67'd0)
      $display("FAIL reset_outputs got busy=%b valid=%b err=%b q=%h r=%h want all zero",
               o_busy, o_valid, o_err, o_quotient, o_remainder);
    else pass++;
    i_reset_n = 1;
    @(negedge i_clk);
    total++;
    if ({o_busy, o_valid} !== 2'b00) $display("FAIL reset_release got busy=%b valid=%b want 0 0", o_busy, o_valid);
    else pass++;
  endtask

  task automatic test_directed;
    logic [31:0] ns [8] = '{32'd100, -32'd100, 32'd100, 32'hFFFFFFFF, 32'h80000000, 32'd12345, 32'h80000001, 32'd0};
    logic [31:0] ds [8] = '{32'd7, 32'd7, -32'd7, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd5};
    logic        ss [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] q, r, eq, er;
    logic e, ee;
    logic [64:0] cl;
    int lat, busy;
    for (int i = 0; i < 8; i++) begin
      do_op(ns[i], ds[i], ss[i], q, r, e, lat, busy, cl);
      model(ns[i], ds[i], ss[i], eq, er, ee);
      total++;
      if ({q, r, e} !== {eq, er, ee})
        $display("FAIL directed%0d_result got q=%h r=%h err=%b want q=%h r=%h err=%b", i, q, r, e, eq, er, ee);
      else pass++;
      total++;
      if ({lat, busy} !== ((ds[i] == 0) ? {32'd2, 32'd0} : {32'd35, 32'd34}))
        $display("FAIL directed%0d_timing got valid_at=%0d busy_cycles=%0d", i, lat, busy);
      else pass++;
      total++;
      if (i > 0 && cl !== 65'd0) $display("FAIL directed%0d_clear got %h want 0", i, cl);
      else pass++;
    end
    total++;
    if ({q, r} !== {32'd0, 32'd0} || e !== 1'b0)
      $display("FAIL directed_zero_num got q=%h r=%h err=%b want 0 0 0", q, r, e);
    else pass++;
  endtask

  task automatic test_hold;
    logic [31:0] q, r;
    logic e;
    logic [64:0] cl;
    int lat, busy;
    do_op(32'd100, 32'd7, 1'b0, q, r, e, lat, busy, cl);
    repeat (5) @(negedge i_clk);
    total++;
    if ({o_valid, o_busy, o_err, o_quotient, o_remainder} !== {3'b000, 32'd14, 32'd2})
      $display("FAIL hold got valid=%b busy=%b err=%b q=%h r=%h want 0 0 0 0000000e 00000002",
               o_valid, o_busy, o_err, o_quotient, o_remainder);
    else pass++;
  endtask

  task automatic test_random;
    logic [31:0] n, d, q, r, eq, er;
    logic s, e, ee;
    logic [64:0] cl;
    int lat, busy;
    for (int i = 0; i < 40; i++) begin
      n = $urandom; s = 1'($urandom);
      case ($urandom_range(0, 3))
        0: d = 0;
        1: d = $urandom_range(1, 20);
        2: d = $urandom;
        default: d = -32'($urandom_range(1, 20));
      endcase
      do_op(n, d, s, q, r, e, lat, busy, cl);
      model(n, d, s, eq, er, ee);
      total++;
      if ({q, r, e} !== {eq, er, ee} || lat != ((d == 0) ? 2 : 35) || busy != ((d == 0) ? 0 : 34) || cl !== 65'd0)
        $display("FAIL random%0d n=%h d=%h s=%b got q=%h r=%h err=%b at=%0d busy=%0d want q=%h r=%h err=%b",
                 i, n, d, s, q, r, e, lat, busy, eq, er, ee);
      else pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ns [3], ds [3], eq, er;
    logic        ss [3];
    logic ee, seen;
    int cnt, k;
    for (int i = 0; i < 3; i++) begin
      ns[i] = $urandom; ds[i] = $urandom | 32'h1; ss[i] = 1'($urandom);
    end
    @(negedge i_clk);
    i_wr = 1; i_numerator = 32'd1000; i_denominator = 32'd3; i_signed = 0;
    repeat (10) @(negedge i_clk);
    total++;
    if (o_busy !== 1'b1) $display("FAIL abort_midcalc got busy=%b want 1", o_busy);
    else pass++;
    #2 i_reset_n = 0;
    #1;
    total++;
    if ({o_busy, o_valid, o_quotient} !== 34'd0) $display("FAIL abort_async got busy=%b valid=%b q=%h want 0", o_busy, o_valid, o_quotient);
    else pass++;
    seen = 0;
    repeat (3) begin @(negedge i_clk); seen |= o_valid; end
    i_reset_n = 1;
    i_numerator = ns[0]; i_denominator = ds[0]; i_signed = ss[0];
    cnt = 0; k = 0;
    while (k < 3 && cnt < 200) begin
      @(negedge i_clk);
      cnt++;
      if (o_valid) begin
        model(ns[k], ds[k], ss[k], eq, er, ee);
        total++;
        if ({o_quotient, o_remainder, o_err} !== {eq, er, ee} || cnt != 35 + 36 * k)
          $display("FAIL b2b%0d got q=%h r=%h err=%b at=%0d want q=%h r=%h err=%b at=%0d",
                   k, o_quotient, o_remainder, o_err, cnt, eq, er, ee, 35 + 36 * k);
        else pass++;
        k++;
        if (k < 3) begin i_numerator = ns[k]; i_denominator = ds[k]; i_signed = ss[k]; end
      end else if (o_busy) begin
        i_numerator = $urandom; i_denominator = $urandom; i_signed = 1'($urandom);
      end
    end
    i_wr = 0;
    total++;
    if (k != 3 || seen) $display("FAIL b2b_done got ops=%0d aborted_valid=%b want 3 0", k, seen);
    else pass++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_hold;
    test_random;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/tl45_divider.md
TL45_DIVIDER -- requirements
Module: tl45_divider

Interface
REQ-001 Parameter W, default 32, sets the operand, quotient and remainder width in bits; only W=32 is required to be supported.
REQ-002 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 i_wr  input  1  start request; sampled only in IDLE.
REQ-005 i_signed  input  1  1 = two's-complement divide; 0 = unsigned divide.
REQ-006 i_numerator  input  W  dividend; captured on an accepted i_wr.
REQ-007 i_denominator  input  W  divisor; captured on an accepted i_wr.
REQ-008 o_busy  output  1  a division is in progress; new i_wr is ignored.
REQ-009 o_valid  output  1  one-cycle pulse; o_quotient, o_remainder and o_err are valid.
REQ-010 o_err  output  1  divide-by-zero flag; qualified by o_valid.
REQ-011 o_quotient  output  W  quotient result.
REQ-012 o_remainder  output  W  remainder result.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, FIXUP and DONE.
REQ-014 IDLE SHALL accept i_wr=1 at edge t, latch the operands and i_signed, and leave o_valid=0.
REQ-015 If the latched denominator is nonzero, the FSM SHALL go to CALC; if it is zero, it SHALL go to DONE.
REQ-016 In IDLE, o_busy SHALL be 0.
REQ-017 In CALC and FIXUP, o_busy SHALL be 1.
REQ-018 In DONE, o_busy SHALL be 0 and o_valid SHALL be 1.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-020 For a signed operation, operand magnitudes SHALL be taken at capture, and the result signs SHALL be recorded:
- quotient negative = sign(num) XOR sign(den);
- remainder negative = sign(num).
REQ-021 For an unsigned operation, operands SHALL be used unmodified.
REQ-022 CALC SHALL run exactly W cycles of radix-2 restoring division, tracked by a counter from W-1 down to 0.
REQ-023 Each CALC cycle SHALL:
- shift {partial remainder, quotient} left by 1;
- subtract the divisor magnitude using a W+1-bit subtraction;
- if the result is non-negative, keep the difference and set the quotient LSB to 1;
- otherwise restore the remainder and set the quotient LSB to 0.
REQ-024 After the counter reaches 0, the FSM SHALL go to FIXUP.
REQ-025 FIXUP SHALL conditionally two's-complement-negate the quotient and the remainder per REQ-020, then go to DONE.
REQ-026 Latency SHALL be fixed: an i_wr accepted at edge t with nonzero divisor gives o_valid=1 in the cycle after edge t+W+2, i.e. W+2 cycles of o_busy=1.
REQ-027 Divide-by-zero SHALL give o_valid=1 and o_err=1 in the cycle after edge t+1, with o_quotient=all-ones and o_remainder=numerator, regardless of i_signed.
REQ-028 o_err SHALL be 0 for every nonzero divisor.
REQ-029 Signed -2^(W-1) / -1 SHALL wrap: o_quotient=0x80000000, o_remainder=0, o_err=0.
REQ-030 i_wr asserted while o_busy=1 SHALL be ignored and SHALL NOT corrupt the in-flight operation.
REQ-031 i_wr asserted in the DONE cycle SHALL be ignored.
REQ-032 Operand inputs SHALL be don't-care after capture, so the requester need not hold them.
REQ-033 o_quotient, o_remainder and o_err SHALL hold their last result from DONE until the next accepted i_wr.
REQ-034 At the edge where i_wr is accepted, o_quotient, o_remainder and o_err SHALL be cleared to 0.
REQ-035 The requester SHALL be able to issue a new i_wr in the cycle immediately after DONE (back-to-back).

Reset
REQ-036 While i_reset_n=0, the FSM SHALL be IDLE; o_busy, o_valid and o_err SHALL be 0; o_quotient, o_remainder and the counter SHALL be 0.
REQ-037 Reset asserted mid-CALC SHALL abort immediately with no o_valid pulse.
REQ-038 After reset deasserts, the first i_wr SHALL be accepted normally.

Verification
REQ-039 Unsigned 100/7 -> after W+2 busy cycles: o_valid pulse, quotient 14, remainder 2, o_err 0.
REQ-040 Signed -100/7 -> quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2); signed 100/-7 -> quotient -14, remainder 2.
REQ-041 Unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-042 Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0, o_err 0.
REQ-043 Any numerator / 0 -> o_valid and o_err one cycle after accept; quotient 0xFFFFFFFF; o_busy never 1.
REQ-044 i_wr held high continuously, with i_reset_n pulsed low mid-CALC -> no o_valid for the aborted op; a fresh op starts on the first edge after release; a second op starts immediately after each DONE; operand changes during busy have no effect.
